uart_tx_fifo_drain: RTL
=======================

# uart_tx_fifo_drain

Serial transmitter that drains the byte FIFO from its read side. Pops one word when the FIFO reports `notEmpty`, then serializes it LSB-first on `tx` as a standard 8N1 asynchronous frame. It sits between the TX FIFO and the UART pin, and is the consumer counterpart of the FIFO's write-side producer.

## Interface
- `DATA_WIDTH`, 8: data bits per frame; must match the FIFO data width.
- `CLK_DIV`, 16: clock cycles per serial bit; valid range 2..65535.
- `DIV_WIDTH`, 16: width of the bit-timer counter; must satisfy 2**DIV_WIDTH > CLK_DIV.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `tx_en`  in  1  permits new frames to start; sampled on each start decision.
- `fifo_dout`  in  DATA_WIDTH  FIFO head word; show-ahead, valid while `fifo_not_empty`=1.
- `fifo_not_empty`  in  1  FIFO `notEmpty`.
- `fifo_rd`  out  1  FIFO `RD`; single-cycle pop strobe; combinational.
- `tx`  out  1  serial line; registered; idles high.
- `busy`  out  1  1 while a frame is in progress (state != IDLE).
- `frame_done`  out  1  one-cycle pulse in the last cycle of each stop bit.

## Operation
- States: IDLE, START, DATA, (PARITY), STOP.
- Pop condition `pop` = `tx_en` & `fifo_not_empty` & (state==IDLE | (state==STOP & bit_tmr==CLK_DIV-1)). `fifo_rd` = `pop` & `rst_n`.
- On `pop`: `fifo_dout` is captured into the shift register, bit_tmr is set to 0, and the state goes to START.
- Each of START/DATA/PARITY/STOP lasts exactly CLK_DIV cycles. bit_tmr counts from 0 to CLK_DIV-1, then clears.
- START drives `tx`=0.
- DATA drives the shift register's bit 0 on `tx`, shifts right at the end of each bit, and counts DATA_WIDTH bits with bit_cnt. Bit_cnt is sized $clog2(DATA_WIDTH+1).
- STOP drives `tx`=1.
- At the end of STOP: if `pop`, the state goes directly to START (back-to-back frames, no idle gap); otherwise it goes to IDLE.
- `tx_en` falling mid-frame: the current frame completes normally and no further pops occur.
- Empty FIFO: `fifo_rd` is never asserted while `fifo_not_empty`=0, so the FIFO is never underflowed.
- Reset values:
  - State: IDLE.
  - `tx`=1, `busy`=0, `frame_done`=0, `fifo_rd`=0.
  - Shift register 0; bit_tmr 0; bit_cnt 0.
- Reset mid-frame: `tx` returns high asynchronously, the in-flight byte is discarded, and nothing is re-popped.

## Timing
- Cycle N: `fifo_rd`=1 in IDLE.
- Cycle N+1: `tx` falls. The start bit occupies cycles N+1..N+CLK_DIV.
- Data bit k occupies cycles N+1+(k+1)*CLK_DIV .. N+(k+2)*CLK_DIV.
- Frame length is exactly (2+DATA_WIDTH)*CLK_DIV cycles, or (3+DATA_WIDTH)*CLK_DIV with parity.
- `busy` rises at N+1. It falls the cycle after the last stop-bit cycle unless a back-to-back pop occurs, in which case it stays high.
- `frame_done` and a back-to-back `fifo_rd` occur in the same cycle. The next start bit begins on the following cycle.

## Configuration
- `UART_TX_PARITY_EN` defined: adds a PARITY state of CLK_DIV cycles between DATA and STOP. The state drives the even-parity bit, which is the XOR of all data bits, captured at pop.
- `UART_TX_PARITY_EN` undefined: the PARITY state and parity logic are absent and the frame is 8N1.

## Test plan
- Single byte, CLK_DIV=4, FIFO holds 0xA5, `tx_en`=1:
  - One `fifo_rd` pulse.
  - `tx`, sampled mid-bit: 0,1,0,1,0,0,1,0,1,1.
  - `busy` high for 40 cycles.
  - One `frame_done` pulse.
- Back-to-back, CLK_DIV=4, FIFO holds 0x00 then 0xFF:
  - Second `fifo_rd` coincides with the first `frame_done`.
  - Second start bit begins on the next cycle.
  - Total 80 cycles with `busy` continuously high.
- Empty FIFO with `tx_en`=1 for 100 cycles:
  - `fifo_rd`=0 and `tx`=1 throughout.
  - `busy`=0.
- `fifo_not_empty`=1, `tx_en`=0: no pop. After `tx_en` rises, `fifo_rd` pulses in that same cycle.
- Reset mid-frame: assert `rst_n`=0 at bit 3 of 0x3C.
  - `tx`=1 and `busy`=0 immediately, with no clock edge required.
  - After release with the FIFO empty, there is no further activity.
- With `UART_TX_PARITY_EN`, CLK_DIV=4, byte 0x07:
  - Parity bit is 1.
  - Frame is 44 cycles.
  - `tx` sequence: 0,1,1,1,0,0,0,0,0,1,1.

Source files
------------

// File: rtl/uart_tx_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_drain
// Purpose  : Read-side consumer of a show-ahead byte FIFO. Pops one word
//            whenever the FIFO is non-empty and transmission is enabled, then
//            serializes it LSB-first as an asynchronous frame
//            (start, DATA_WIDTH data bits, optional even parity, one stop).
//            Back-to-back frames are sent with no idle gap.
// Options  : define UART_TX_PARITY_EN to insert an even-parity bit between
//            the last data bit and the stop bit.
// Ports    : clk              system clock, rising edge
//            rst_n            asynchronous active-low reset
//            tx_en_i          permits new frames to start
//            fifo_dout_i      FIFO head word (valid while not empty)
//            fifo_not_empty_i FIFO notEmpty flag
//            fifo_rd_o        single-cycle pop strobe (combinational)
//            tx_o             serial line, registered, idles high
//            busy_o           high while a frame is in progress
//            frame_done_o     pulse in the last cycle of each stop bit
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tx_en_i,
  input  logic [DATA_WIDTH-1:0] fifo_dout_i,
  input  logic                  fifo_not_empty_i,
  output logic                  fifo_rd_o,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  frame_done_o
);

  localparam int CNT_WIDTH = $clog2(DATA_WIDTH + 1);
  localparam logic [DIV_WIDTH-1:0] TMR_LAST = DIV_WIDTH'(CLK_DIV - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [DIV_WIDTH-1:0]    bit_tmr_q, bit_tmr_d;
  logic [CNT_WIDTH-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic                    tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic                    parity_q, parity_d;
`endif

  logic w_tmr_end;
  logic w_pop;

  assign w_tmr_end = (bit_tmr_q == TMR_LAST);

  // A new word may be taken while idle, or in the final stop-bit cycle so
  // the next start bit follows without a gap.
  assign w_pop = tx_en_i & fifo_not_empty_i &
                 ((state_q == IDLE) | ((state_q == STOP) & w_tmr_end));

  // Gate with rst_n so no pop strobe reaches the FIFO while held in reset.
  assign fifo_rd_o    = w_pop & rst_n;
  assign busy_o       = (state_q != IDLE);
  assign frame_done_o = (state_q == STOP) & w_tmr_end;
  assign tx_o         = tx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_tmr_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_tmr_q <= bit_tmr_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_tmr_d = bit_tmr_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    tx_d      = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      IDLE: begin
        if (w_pop) begin
          state_d   = START;
          bit_tmr_d = '0;
          bit_cnt_d = '0;
          shreg_d   = fifo_dout_i;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^fifo_dout_i;
`endif
        end
      end

      START: begin
        if (w_tmr_end) begin
          state_d   = DATA;
          bit_tmr_d = '0;
          bit_cnt_d = '0;
        end else begin
          bit_tmr_d = bit_tmr_q + 1'b1;
        end
      end

      DATA: begin
        if (w_tmr_end) begin
          bit_tmr_d = '0;
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CNT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          bit_tmr_d = bit_tmr_q + 1'b1;
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_tmr_end) begin
          state_d   = STOP;
          bit_tmr_d = '0;
        end else begin
          bit_tmr_d = bit_tmr_q + 1'b1;
        end
      end
`endif

      STOP: begin
        if (w_tmr_end) begin
          bit_tmr_d = '0;
          if (w_pop) begin
            state_d   = START;
            bit_cnt_d = '0;
            shreg_d   = fifo_dout_i;
`ifdef UART_TX_PARITY_EN
            parity_d  = ^fifo_dout_i;
`endif
          end else begin
            state_d = IDLE;
          end
        end else begin
          bit_tmr_d = bit_tmr_q + 1'b1;
        end
      end

      default: begin
        state_d   = IDLE;
        bit_tmr_d = '0;
        bit_cnt_d = '0;
      end
    endcase

    // The line is registered, so it is derived from the state being entered.
    // The shift register only moves at bit boundaries, so bit 0 of the next
    // value is the data bit for the coming cycle.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

endmodule
`default_nettype wire
